// File: rtl/dcb277_alu_seg7.sv
// dcb277_alu_seg7
// 4-bit registered ALU with a hexadecimal 7-segment display of the result,
// wrapped in the standard user-project pin interface.
//
// Ports:
//   clk      system clock, rising edge active
//   rst_n    asynchronous active-low reset
//   ena      clock enable; the result and flag registers hold while low
//   ui_in    [3:0] = operand A, [7:4] = operand B
//   uio_in   [3:0] = function code, [7:4] ignored
//   uo_out   [6:0] = segments g..a of the result (active high), [7] = C flag
//   uio_out  [3:0] = 0, [4] = C, [5] = Z, [6] = N, [7] = V
//   uio_oe   constant 8'hF0 (high nibble driven as outputs)
module dcb277_alu_seg7 #(
  parameter int WIDTH = 4  // fixed at 4; the pin map depends on it
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [3:0] {
    FN_ADD  = 4'b0000,
    FN_SUB  = 4'b0001,
    FN_AND  = 4'b0100,
    FN_OR   = 4'b0101,
    FN_XOR  = 4'b0110,
    FN_SLL  = 4'b1000,
    FN_SRL  = 4'b1001,
    FN_SRA  = 4'b1010,
    FN_PASS = 4'b1111
  } func_e;

  logic [WIDTH-1:0] a, b;
  logic [3:0]       func;

  assign a    = ui_in[3:0];
  assign b    = ui_in[7:4];
  assign func = uio_in[3:0];

  // High nibble of uio_in has no function.
  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:4]};

  logic [WIDTH-1:0] y_d, y_q;
  logic             c_d, c_q;
  logic             z_d, z_q;
  logic             n_d, n_q;
  logic             v_d, v_q;

  // Shared adder: subtraction reuses it as A + ~B + 1.
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             big_shift;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    y_d       = '0;
    c_d       = 1'b0;
    v_d       = 1'b0;
    b_eff     = (func == FN_SUB) ? ~b : b;
    cin       = (func == FN_SUB);
    sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    big_shift = (b >= 4'd4);

    unique case (func)
      FN_ADD, FN_SUB: begin
        y_d = sum[WIDTH-1:0];
        // For subtraction the carry out is the inverted borrow.
        c_d = sum[WIDTH];
        // Overflow: operands of equal sign produce a result of the other sign.
        v_d = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      FN_AND:  y_d = a & b;
      FN_OR:   y_d = a | b;
      FN_XOR:  y_d = a ^ b;
      FN_SLL:  y_d = big_shift ? '0 : (a << b[1:0]);
      FN_SRL:  y_d = big_shift ? '0 : (a >> b[1:0]);
      FN_SRA:  y_d = big_shift ? {WIDTH{a[WIDTH-1]}}
                               : $unsigned($signed(a) >>> b[1:0]);
      FN_PASS: y_d = a;
      default: y_d = '0;
    endcase

    z_d = (y_d == '0);
    n_d = y_d[WIDTH-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      c_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else if (ena) begin
      y_q <= y_d;
      c_q <= c_d;
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
    end
  end

  // Hex digit to segments g..a, active high.
  logic [6:0] seg;

  always_comb begin
    seg = 7'h00;
    unique case (y_q)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  assign uo_out  = {c_q, seg};
  assign uio_out = {v_q, n_q, z_q, c_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_dcb277_alu_seg7.sv
// Self-checking bench for dcb277_alu_seg7: directed cases from the feature
// list followed by randomized operations, all compared against an integer
// reference model of the ALU and display.
module tb_dcb277_alu_seg7;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_y, m_c, m_z, m_n, m_v;

  logic [6:0] seg_tab [16];

  dcb277_alu_seg7 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int to_signed4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  task automatic model_op(input int a, input int b, input int f);
    int sa, sb, r;
    sa  = to_signed4(a);
    sb  = to_signed4(b);
    m_c = 0;
    m_v = 0;
    case (f)
      0: begin
        r   = a + b;
        m_c = (r > 15);
        m_v = ((sa + sb) > 7 || (sa + sb) < -8);
        m_y = r % 16;
      end
      1: begin
        m_c = (a >= b);
        m_v = ((sa - sb) > 7 || (sa - sb) < -8);
        m_y = (a - b + 16) % 16;
      end
      4:  m_y = a & b;
      5:  m_y = a | b;
      6:  m_y = a ^ b;
      8:  m_y = (b >= 4) ? 0 : (a * (1 << b)) % 16;
      9:  m_y = a / (1 << b);
      10: m_y = (b >= 4) ? ((sa < 0) ? 15 : 0) : (sa >>> b) & 15;
      15: m_y = a;
      default: m_y = 0;
    endcase
    m_z = (m_y == 0);
    m_n = (m_y >= 8);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".uo"},  uo_out,  {24'd0, m_c[0], seg_tab[m_y]});
    check({tag, ".uio"}, uio_out, {24'd0, m_v[0], m_n[0], m_z[0], m_c[0], 4'b0000});
    check({tag, ".oe"},  uio_oe,  32'h0000_00F0);
  endtask

  // Apply one operation between edges, clock it, then compare.
  task automatic step(input string tag, input int a, input int b, input int f, input bit en);
    @(negedge clk);
    ui_in  = {b[3:0], a[3:0]};
    uio_in = {4'($urandom_range(0, 15)), f[3:0]};
    ena    = en;
    @(posedge clk);
    #1;
    if (en) model_op(a, b, f);
    check_outputs(tag);
  endtask

  task automatic reset_model();
    m_y = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    reset_model();

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("reset.uo",  uo_out,  32'h3F);
    check("reset.uio", uio_out, 32'h00);
    check("reset.oe",  uio_oe,  32'hF0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Add wrap and overflow.
    step("add_wrap", 2, 14, 0, 1'b1);
    check("add_wrap.seg", uo_out, 32'hBF);  // "0" with C=1
    step("add_ovf", 7, 1, 0, 1'b1);
    check("add_ovf.seg", uo_out[6:0], 32'h7F);
    // Subtract with and without borrow.
    step("sub_borrow", 2, 4, 1, 1'b1);
    check("sub_borrow.seg", uo_out[6:0], 32'h79);
    step("sub_equal", 4, 4, 1, 1'b1);
    // Logic operations and an undefined code.
    step("and", 6, 6, 4, 1'b1);
    check("and.seg", uo_out[6:0], 32'h7D);
    step("or",  6, 6, 5, 1'b1);
    step("xor", 6, 6, 6, 1'b1);
    step("undef", 6, 6, 3, 1'b1);
    // Shifts, including shift amounts of four or more.
    step("sra1", 8, 1, 10, 1'b1);
    check("sra1.seg", uo_out[6:0], 32'h39);
    step("srl1", 8, 1, 9, 1'b1);
    check("srl1.seg", uo_out[6:0], 32'h66);
    step("sll2", 3, 2, 8, 1'b1);
    step("sra5", 8, 5, 10, 1'b1);
    step("srl5", 8, 5, 9, 1'b1);
    step("sll4", 15, 4, 8, 1'b1);

    // Enable: registers hold while ena is low, update one edge after it rises.
    step("hold0", 5, 0, 15, 1'b0);
    step("hold1", 5, 0, 15, 1'b0);
    @(negedge clk);
    ena = 1'b1;
    #1;
    check_outputs("pre_edge");
    @(posedge clk);
    #1;
    model_op(5, 0, 15);
    check_outputs("ena_rise");
    check("ena_rise.seg", uo_out[6:0], 32'h6D);

    // Reset mid-operation, then a normal first capture.
    step("pre_rst", 9, 3, 0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_model();
    check_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 7, 6, 1, 1'b1);

    // Randomized operations with a mix of enabled and held cycles.
    for (int i = 0; i < 300; i++) begin
      int f;
      f = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(0, 15))
                                         : int'($urandom_range(0, 10) == 10 ? 15 : $urandom_range(0, 10));
      step("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), f,
           ($urandom_range(0, 4) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
